slow_access_timer: RTL and testbench
====================================

// Module: slow_access_timer
// PURPOSE
//  Downstream consumer of the slow-access settings register (Slow* enables, SlowTimeout).
//  Detects CPU bus accesses to I/O regions whose slow-enable bit is set.
//  Holds the accelerator in slow (stock-speed) mode for the access, plus a programmable tail.
//  Drives Slow to the CPU clock/DTACK logic and ClockGate to the fast-clock gate.
// PARAMETERS
//  TSHIFT  4  tail length = SlowTimeout << TSHIFT Tick periods; counter width = 4+TSHIFT
// PORTS
//  CLK          in   1  system clock, all logic on rising edge
//  POR          in   1  synchronous active-high reset
//  BACT         in   1  CPU bus access active
//  IACKCS       in   1  interrupt-acknowledge cycle decode
//  VIACS        in   1  VIA select
//  IWMCS        in   1  IWM select
//  SCCCS        in   1  SCC select
//  SCSICS       in   1  SCSI select
//  SndCS        in   1  sound/PWM buffer RAM select
//  SlowIACK     in   1  enables for the matching region (from settings register)
//  SlowVIA      in   1
//  SlowIWM      in   1
//  SlowSCC      in   1
//  SlowSCSI     in   1
//  SlowSnd      in   1
//  SlowClockGate in  1  permit fast-clock gating while slow
//  SlowTimeout  in   4  tail length code; 0 = no tail
//  Tick         in   1  one-CLK-wide timebase strobe
//  Slow         out  1  registered slow-mode request
//  ClockGate    out  1  registered; Slow && SlowClockGate
//  Busy         out  1  registered; state != IDLE (status)
// BEHAVIOUR
//  Hit = BACT && !BACTr && |(CS & enable); BACTr = BACT delayed 1 CLK. Hit = first access cycle only.
//  States: IDLE, HOLD (access in progress), TAIL (counting down).
//  Reset: state=IDLE, Cnt=0, Slow=0, ClockGate=0, Busy=0, BACTr=0. Effective next edge; aborts any op.
//  IDLE: Hit -> HOLD. Slow=1 on the edge after the Hit cycle (latency 1 CLK).
//  HOLD: stay while BACT=1. On BACT=0:
//    SlowTimeout==0 -> IDLE (Slow=0 next edge).
//    else load Cnt = SlowTimeout << TSHIFT -> TAIL.
//  SlowTimeout is sampled only at load; later writes do not affect a running tail.
//  TAIL: Tick decrements Cnt. Tick with Cnt==1 -> IDLE, Cnt=0 -> tail = exactly N ticks.
//    Hit in TAIL -> HOLD (retrigger); Cnt is not decremented that cycle.
//    Hit and Tick in the same cycle: Hit wins.
//  Slow=1 in HOLD and TAIL; Slow=0 in IDLE. ClockGate follows Slow && current SlowClockGate, registered.
//  A new access without a Hit (region disabled) in TAIL does not alter the tail.
//  Tick during HOLD is ignored. No wrap: Cnt never decrements below 0.
// CONFIGURATION
//  SLOW_FORCE_EN defined: adds input ForceSlow (1b, synchronous).
//    ForceSlow=1: Slow=1 and ClockGate=SlowClockGate next edge, regardless of state.
//    Cnt is frozen (Ticks ignored). Hits are still tracked.
//    On release, the FSM resumes from its frozen state.
//  SLOW_FORCE_EN undefined: no ForceSlow port; Slow derives from FSM only.
// TESTING
//  POR=1 for 2 CLK with BACT=1, VIACS=1 -> Slow=0, ClockGate=0, Busy=0 throughout reset.
//  SlowVIA=1, SlowTimeout=2, TSHIFT=4; VIA access 3 CLK -> Slow rises 1 CLK after BACT rises.
//    Slow stays high for exactly 32 Ticks after BACT falls, then 0.
//  SlowSCC=0, SCC access -> Slow stays 0. SlowSCC=1, SlowTimeout=0 -> Slow high exactly during the access, +1 CLK latency.
//  Tail at Cnt=5; new IWM access (SlowIWM=1) with simultaneous Tick -> HOLD.
//    After release, Cnt reloads to full SlowTimeout<<4; tail is not shortened.
//  SlowTimeout changed 3->1 mid-tail -> the current tail still runs 48 Ticks; the next access uses 16.
//  SLOW_FORCE_EN: ForceSlow=1 mid-tail for 10 Ticks -> Slow=1 and Cnt unchanged.
//    After release, the remaining tail completes. SlowClockGate=1 -> ClockGate tracks Slow.

Source files
------------

// File: rtl/slow_access_timer.sv
// Slow-access timer: holds the accelerator at stock speed for slow I/O accesses plus a tail.
// Optional feature macro: SLOW_FORCE_EN adds a ForceSlow input that forces slow mode.
module slow_access_timer #(
  parameter int TSHIFT = 4
) (
  input  logic       CLK,
  input  logic       POR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  input  logic       Tick,
`ifdef SLOW_FORCE_EN
  input  logic       ForceSlow,
`endif
  output logic       Slow,
  output logic       ClockGate,
  output logic       Busy
);

  localparam int CW = 4 + TSHIFT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic            bactr;
  logic [5:0]      cs;
  logic [5:0]      en;
  logic            hit;
  logic            frz;
  logic            tick;
  logic            slow_n;

  assign cs = {SndCS, SCSICS, SCCCS, IWMCS, VIACS, IACKCS};
  assign en = {SlowSnd, SlowSCSI, SlowSCC, SlowIWM, SlowVIA, SlowIACK};

  // only the first cycle of an access to an enabled region counts
  assign hit = BACT && !bactr && (|(cs & en));

`ifdef SLOW_FORCE_EN
  assign frz = ForceSlow;
`else
  assign frz = 1'b0;
`endif

  // a forced-slow period freezes the tail count
  assign tick = Tick && !frz;

  // next-state and tail counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (hit) state_n = HOLD;
      end
      HOLD: begin
        if (!BACT) begin
          if (SlowTimeout == 4'd0) begin
            state_n = IDLE;
          end else begin
            cnt_n   = CW'(SlowTimeout) << TSHIFT;
            state_n = TAIL;
          end
        end
      end
      TAIL: begin
        if (hit) begin
          state_n = HOLD;
        end else if (tick) begin
          if (cnt <= CW'(1)) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign slow_n = (state_n != IDLE) || frz;

  // state, counter and registered outputs
  always_ff @(posedge CLK) begin
    if (POR) begin
      state     <= IDLE;
      cnt       <= '0;
      bactr     <= 1'b0;
      Slow      <= 1'b0;
      ClockGate <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bactr     <= BACT;
      Slow      <= slow_n;
      ClockGate <= slow_n && SlowClockGate;
      Busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_slow_access_timer.sv
// Bench for slow_access_timer: directed scenarios plus random bursts
// checked against a tick-budget reference model.
module tb_slow_access_timer;

  logic       clk = 1'b0;
  logic       por = 1'b1;
  logic       bact = 1'b0;
  logic [5:0] cs = '0;
  logic [5:0] en = '0;
  logic       scg = 1'b0;
  logic [3:0] tmo = '0;
  logic       tick = 1'b0;
  logic       force_slow = 1'b0;
  logic       slow;
  logic       cgate;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bit hold = 0;
  int tail_left = 0;
  bit bprev = 0;

  always #5 clk = ~clk;

  slow_access_timer #(.TSHIFT(4)) dut (
    .CLK(clk),
    .POR(por),
    .BACT(bact),
    .IACKCS(cs[0]),
    .VIACS(cs[1]),
    .IWMCS(cs[2]),
    .SCCCS(cs[3]),
    .SCSICS(cs[4]),
    .SndCS(cs[5]),
    .SlowIACK(en[0]),
    .SlowVIA(en[1]),
    .SlowIWM(en[2]),
    .SlowSCC(en[3]),
    .SlowSCSI(en[4]),
    .SlowSnd(en[5]),
    .SlowClockGate(scg),
    .SlowTimeout(tmo),
    .Tick(tick),
`ifdef SLOW_FORCE_EN
    .ForceSlow(force_slow),
`endif
    .Slow(slow),
    .ClockGate(cgate),
    .Busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: update the model with the applied inputs, then compare
  task automatic step();
    bit h;
    bit s;
    @(posedge clk);
    if (por) begin
      hold = 0;
      tail_left = 0;
      bprev = 0;
    end else begin
      h = bact && !bprev && ((cs & en) != 6'd0);
      if (h) begin
        hold = 1;
        tail_left = 0;
      end else if (hold && !bact) begin
        hold = 0;
        tail_left = int'(tmo) * 16;
      end else if (!hold && tail_left > 0 && tick) begin
        tail_left--;
      end
      bprev = bact;
    end
    s = hold || (tail_left > 0);
    #1;
    check("slow", slow, s);
    check("clockgate", cgate, s && scg && !por);
    check("busy", busy, s);
  endtask

  task automatic access(input int region, input int len);
    cs = '0;
    cs[region] = 1'b1;
    bact = 1'b1;
    for (int i = 0; i < len; i++) step();
    bact = 1'b0;
    cs = '0;
  endtask

  // tick every other cycle until Slow drops; returns ticks applied
  task automatic tail_len(output int n);
    int k;
    n = 0;
    k = 0;
    while (slow && k < 400) begin
      tick = k[0];
      step();
      if (tick) n++;
      k++;
    end
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  initial begin
    int n;
    // reset with an access pending
    por = 1'b1;
    bact = 1'b1;
    cs = 6'b000010;
    en = 6'b111111;
    scg = 1'b1;
    step();
    check("rst_slow0", slow, 0);
    step();
    check("rst_slow1", slow, 0);
    check("rst_cg", cgate, 0);
    check("rst_busy", busy, 0);
    bact = 1'b0;
    cs = '0;
    step();
    por = 1'b0;
    step();

    // VIA access, 32-tick tail
    en = 6'b000010;
    tmo = 4'd2;
    cs = 6'b000010;
    bact = 1'b1;
    step();
    check("via_latency", slow, 1);
    step();
    step();
    bact = 1'b0;
    cs = '0;
    tail_len(n);
    check("via_tail", n, 32);

    // disabled SCC stays fast
    en = 6'b000000;
    access(3, 3);
    check("scc_off", slow, 0);
    step();
    check("scc_off2", slow, 0);

    // SCC with no tail: slow only for the access
    en = 6'b001000;
    tmo = 4'd0;
    n = 0;
    access(3, 4);
    step();
    check("scc_notail", slow, 0);

    // retrigger at Cnt=5 with a simultaneous tick
    en = 6'b000100;
    tmo = 4'd1;
    access(2, 2);
    step();
    ticks(11);
    cs = 6'b000100;
    bact = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    check("retrig_hold", busy, 1);
    bact = 1'b0;
    cs = '0;
    tail_len(n);
    check("retrig_tail", n, 16);

    // timeout change mid-tail
    tmo = 4'd3;
    access(2, 2);
    step();
    ticks(5);
    tmo = 4'd1;
    tail_len(n);
    check("tmo_change", n + 5, 48);
    access(2, 2);
    tail_len(n);
    check("tmo_next", n, 16);

    // random bursts
    for (int b = 0; b < 300; b++) begin
      int gap;
      int len;
      en = 6'($urandom);
      tmo = 4'($urandom_range(0, 3));
      scg = 1'($urandom);
      gap = $urandom_range(0, 25);
      for (int i = 0; i < gap; i++) begin
        tick = ($urandom_range(0, 2) == 0);
        cs = 6'($urandom);
        por = ($urandom_range(0, 300) == 0);
        if ($urandom_range(0, 9) == 0) tmo = 4'($urandom_range(0, 3));
        step();
      end
      por = 1'b0;
      len = $urandom_range(1, 4);
      cs = 6'($urandom);
      bact = 1'b1;
      for (int i = 0; i < len; i++) begin
        tick = 1'($urandom);
        step();
      end
      bact = 1'b0;
      tick = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
